block_scheduler: RTL
====================

BLOCK_SCHEDULER -- requirements
Module: block_scheduler

Interface
REQ-001 Parameter TIMEOUT, default 15: max cycles spent in WAIT before aborting a job (range 2..255).
REQ-002 Parameter MIN_WAIT, default 2: cycles after operand load before bk_rdy is sampled (range 1..TIMEOUT-1).
REQ-003 clk  in  1  single clock, all state on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 req_valid  in  2  per-requester job request (bit i = requester i).
REQ-006 req_data  in  32  operands; requester i on bits [16i+15:16i], nibbles in1..in4 from LSB.
REQ-007 req_ready  out  2  one-hot grant; job accepted on cycle where req_valid[i] & req_ready[i].
REQ-008 rsp_valid  out  1  result available.
REQ-009 rsp_ready  in  1  result consumer accepts.
REQ-010 rsp_id  out  1  index of requester owning the result.
REQ-011 rsp_data  out  4  captured bk_out.
REQ-012 rsp_err  out  1  job aborted by timeout; rsp_data = 0.
REQ-013 bk_in1..bk_in4  out  4 each  operand registers driving the shared block.
REQ-014 bk_out  in  4  block result; bk_proc in 1 block busy; bk_rdy in 1 block result valid.
REQ-015 busy  out  1  high in any state other than IDLE.

Function
REQ-016 States: IDLE, LOAD, WAIT, RESP; exactly one active.
REQ-017 IDLE: req_ready asserted for at most one requester, chosen round-robin; if both valid, the one not granted last wins; if one valid, it wins.
REQ-018 req_ready SHALL be combinational from req_valid and the priority pointer in IDLE only; 0 in all other states.
REQ-019 On acceptance: latch owner id and 16-bit operand, update pointer to owner, go to LOAD next cycle.
REQ-020 LOAD (1 cycle): bk_in1..4 take latched nibbles at end of LOAD; clear wait counter; go to WAIT.
REQ-021 bk_in1..4 SHALL hold their values in all states other than LOAD.
REQ-022 WAIT: counter increments each cycle, saturates at TIMEOUT.
REQ-023 WAIT completes when counter >= MIN_WAIT and bk_rdy=1 and bk_proc=0: capture bk_out into rsp_data, rsp_err=0, go to RESP.
REQ-024 WAIT aborts when counter = TIMEOUT and completion condition false that cycle: rsp_data=0, rsp_err=1, go to RESP.
REQ-025 Completion and timeout in same cycle: completion wins.
REQ-026 RESP: rsp_valid=1, rsp_id/rsp_data/rsp_err stable until rsp_valid & rsp_ready; then IDLE next cycle.
REQ-027 rsp_valid SHALL be registered and asserted only in RESP.
REQ-028 Minimum job latency acceptance-to-rsp_valid: MIN_WAIT+2 cycles; maximum TIMEOUT+2 cycles.
REQ-029 Requests deasserted while not granted are ignored; no request queued internally.

Reset
REQ-030 rst_n low asynchronously forces: state IDLE, pointer to requester 0 as preferred, bk_in1..4=0, counter=0, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0.
REQ-031 Reset mid-job discards the job with no response; outputs take reset values immediately.
REQ-032 First grant after reset SHALL go to requester 0 when both valid.

Structure
REQ-033 Shared package async_proc_pkg: state enumeration, NIBBLE_W=4, OPERAND_W=16, NUM_REQ=2.
REQ-034 Sub-module rr_arbiter2: 2-input round-robin grant with registered last-grant pointer, update enable from parent.
REQ-035 Remaining logic (FSM, counter, operand/result registers) in block_scheduler.

Verification
REQ-036 Reset, req_valid=01, data 0x4321, bk_rdy=1 bk_proc=0 -> bk_in1..4=1,2,3,4; rsp_valid 4 cycles after acceptance, rsp_id=0, rsp_data=bk_out.
REQ-037 Both valid continuously for 4 jobs -> grants 0,1,0,1; rsp_id sequence matches.
REQ-038 bk_rdy held 0 -> rsp_valid with rsp_err=1, rsp_data=0, TIMEOUT+2 cycles after acceptance.
REQ-039 bk_rdy rises exactly on counter=TIMEOUT cycle -> rsp_err=0, data captured.
REQ-040 rsp_ready held 0 for 10 cycles in RESP -> outputs stable, req_ready=00, then IDLE one cycle after handshake.
REQ-041 rst_n pulsed low during WAIT -> all outputs to reset values same cycle, no response, next grant to requester 0.

Source files
------------

// File: rtl/async_proc_pkg.sv
// Shared types and widths for the block scheduler and its round-robin arbiter.
package async_proc_pkg;

  localparam int NIBBLE_W  = 4;
  localparam int OPERAND_W = 16;
  localparam int NUM_REQ   = 2;
  localparam int CNT_W     = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin grant; the last winner loses a tie on the next contest.
module rr_arbiter2
  import async_proc_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               upd,
  output logic [NUM_REQ-1:0] gnt,
  output logic               gnt_id
);

  // Resetting to 1 makes requester 0 the preferred winner of the first tie.
  logic last;

  always_comb begin
    gnt = '0;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = '0;
    endcase
  end

  assign gnt_id = gnt[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   last <= 1'b1;
    else if (upd) last <= gnt_id;
  end

endmodule

// File: rtl/block_scheduler.sv
// Time-multiplexes one shared processing block between two requesters:
// arbitrate, load operands, wait for the block (with timeout), hold the result.
module block_scheduler
  import async_proc_pkg::*;
#(
  parameter int TIMEOUT  = 15,
  parameter int MIN_WAIT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_valid,
  input  logic [31:0] req_data,
  output logic [1:0]  req_ready,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [3:0]  rsp_data,
  output logic        rsp_err,
  output logic [3:0]  bk_in1,
  output logic [3:0]  bk_in2,
  output logic [3:0]  bk_in3,
  output logic [3:0]  bk_in4,
  input  logic [3:0]  bk_out,
  input  logic        bk_proc,
  input  logic        bk_rdy,
  output logic        busy
);

  localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] MW_CNT = CNT_W'(MIN_WAIT);

  state_t                        state, state_nxt;
  logic                          owner;
  logic [OPERAND_W-1:0]          operand;
  logic [3:0][NIBBLE_W-1:0]      bk_in_q;
  logic [CNT_W-1:0]              cnt, cnt_nxt;
  logic [NUM_REQ-1:0]            gnt;
  logic                          gnt_id;
  logic                          idle, accept, done, abort;

  assign idle   = (state == ST_IDLE);
  assign accept = |(req_valid & req_ready);

  rr_arbiter2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req_valid & {NUM_REQ{idle}}),
    .upd    (accept),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  assign req_ready = gnt;

  // cnt_nxt counts WAIT cycles including the current one, so the first
  // WAIT cycle sees 1 and the abort lands TIMEOUT+2 cycles after acceptance.
  assign cnt_nxt = (cnt >= TO_CNT) ? TO_CNT : cnt + 1'b1;
  assign done    = (state == ST_WAIT) && (cnt_nxt >= MW_CNT) && bk_rdy && !bk_proc;
  assign abort   = (state == ST_WAIT) && (cnt_nxt == TO_CNT) && !done;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept)         state_nxt = ST_LOAD;
      ST_LOAD:                     state_nxt = ST_WAIT;
      ST_WAIT: if (done || abort)  state_nxt = ST_RESP;
      ST_RESP: if (rsp_ready)      state_nxt = ST_IDLE;
      default:                     state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner     <= 1'b0;
      operand   <= '0;
      bk_in_q   <= '0;
      cnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (accept) begin
          owner   <= gnt_id;
          operand <= gnt_id ? req_data[31:16] : req_data[15:0];
        end
        ST_LOAD: begin
          bk_in_q <= operand;
          cnt     <= '0;
        end
        ST_WAIT: begin
          cnt <= cnt_nxt;
          if (done) begin
            rsp_valid <= 1'b1;
            rsp_data  <= bk_out;
            rsp_err   <= 1'b0;
          end else if (abort) begin
            rsp_valid <= 1'b1;
            rsp_data  <= '0;
            rsp_err   <= 1'b1;
          end
        end
        ST_RESP: if (rsp_ready) rsp_valid <= 1'b0;
        default: ;
      endcase
    end
  end

  assign rsp_id = owner;
  assign bk_in1 = bk_in_q[0];
  assign bk_in2 = bk_in_q[1];
  assign bk_in3 = bk_in_q[2];
  assign bk_in4 = bk_in_q[3];
  assign busy   = !idle;

endmodule
